// File: rtl/result_uart_reporter.sv
// ---------------------------------------------------------------------------
// result_uart_reporter
//
// Purpose:
//   Sends a snapshot of processor status to the host PC as one ASCII line over
//   UART TX. A one-cycle request latches the FSM state, the ALU left/right
//   nibbles and the negative flag. The block then serialises the 8-character
//   line  'S', HEX(state), ' ', SIGN, HEX(left), HEX(right), CR, LF.
//
// Configuration macro:
//   REPORT_PARITY_EN  - when defined, an even-parity bit follows d7 of every
//                       character (8E1). When undefined the frame is 8N1.
//
// Parameters:
//   CLKS_PER_BIT      - clock cycles per UART bit (2..65535)
//
// Ports:
//   i_Clk       in   system clock, all logic on posedge
//   i_Rst_L     in   synchronous active-low reset
//   i_Send      in   one-cycle request, honoured only while o_Busy is low
//   i_State     in   [3:0] FSM state to report
//   i_Left      in   [3:0] ALU left result nibble
//   i_Right     in   [3:0] ALU right result nibble
//   i_Negative  in   ALU negative flag
//   o_Tx        out  UART serial line, LSB first, idle high
//   o_Busy      out  high while a line is being transmitted
//   o_Done      out  one-cycle pulse after the last stop bit of the line
// ---------------------------------------------------------------------------
module result_uart_reporter #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Send,
    input  logic [3:0] i_State,
    input  logic [3:0] i_Left,
    input  logic [3:0] i_Right,
    input  logic       i_Negative,
    output logic       o_Tx,
    output logic       o_Busy,
    output logic       o_Done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef REPORT_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] baudCnt_q, baudCnt_d;
    logic [2:0]  bitIdx_q, bitIdx_d;
    logic [2:0]  charIdx_q, charIdx_d;
    logic [3:0]  snapState_q, snapState_d;
    logic [3:0]  snapLeft_q, snapLeft_d;
    logic [3:0]  snapRight_q, snapRight_d;
    logic        snapNeg_q, snapNeg_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        bitTick;
    logic        accept;
    logic [7:0]  curChar;

    function automatic logic [7:0] hexAscii(input logic [3:0] n);
        if (n < 4'd10) begin
            return {4'h3, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [7:0] lineChar(
        input logic [2:0] idx,
        input logic [3:0] st,
        input logic [3:0] lf,
        input logic [3:0] rt,
        input logic       neg
    );
        logic [7:0] c;
        case (idx)
            3'd0:    c = 8'h53;
            3'd1:    c = hexAscii(st);
            3'd2:    c = 8'h20;
            3'd3:    c = neg ? 8'h2D : 8'h2B;
            3'd4:    c = hexAscii(lf);
            3'd5:    c = hexAscii(rt);
            3'd6:    c = 8'h0D;
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    // Next-state logic. Outputs are decoded from the *next* state so that they
    // can be registered without adding a cycle of latency: the start bit is on
    // the line the cycle right after acceptance. busy_q is low in both IDLE and
    // DONE, which is what lets a request arriving alongside o_Done start the
    // next line without an idle bit.
    always_comb begin
        state_d     = state_q;
        baudCnt_d   = baudCnt_q;
        bitIdx_d    = bitIdx_q;
        charIdx_d   = charIdx_q;
        snapState_d = snapState_q;
        snapLeft_d  = snapLeft_q;
        snapRight_d = snapRight_q;
        snapNeg_d   = snapNeg_q;
        tx_d        = 1'b1;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        bitTick = (baudCnt_q == BAUD_LAST);
        accept  = i_Send && !busy_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d     = S_START;
                    baudCnt_d   = 16'd0;
                    bitIdx_d    = 3'd0;
                    charIdx_d   = 3'd0;
                    snapState_d = i_State;
                    snapLeft_d  = i_Left;
                    snapRight_d = i_Right;
                    snapNeg_d   = i_Negative;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bitTick) begin
                    baudCnt_d = 16'd0;
                    bitIdx_d  = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    baudCnt_d = baudCnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bitTick) begin
                    baudCnt_d = 16'd0;
                    if (bitIdx_q == 3'd7) begin
`ifdef REPORT_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + 16'd1;
                end
            end
`ifdef REPORT_PARITY_EN
            S_PARITY: begin
                if (bitTick) begin
                    baudCnt_d = 16'd0;
                    state_d   = S_STOP;
                end else begin
                    baudCnt_d = baudCnt_q + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (bitTick) begin
                    baudCnt_d = 16'd0;
                    if (charIdx_q == 3'd7) begin
                        state_d = S_DONE;
                    end else begin
                        charIdx_d = charIdx_q + 3'd1;
                        state_d   = S_START;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        curChar = lineChar(charIdx_d, snapState_d, snapLeft_d, snapRight_d, snapNeg_d);

        case (state_d)
            S_START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
            end
            S_DATA: begin
                tx_d   = curChar[bitIdx_d];
                busy_d = 1'b1;
            end
`ifdef REPORT_PARITY_EN
            S_PARITY: begin
                tx_d   = ^curChar;
                busy_d = 1'b1;
            end
`endif
            S_STOP: begin
                tx_d   = 1'b1;
                busy_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q     <= S_IDLE;
            baudCnt_q   <= 16'd0;
            bitIdx_q    <= 3'd0;
            charIdx_q   <= 3'd0;
            snapState_q <= 4'd0;
            snapLeft_q  <= 4'd0;
            snapRight_q <= 4'd0;
            snapNeg_q   <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baudCnt_q   <= baudCnt_d;
            bitIdx_q    <= bitIdx_d;
            charIdx_q   <= charIdx_d;
            snapState_q <= snapState_d;
            snapLeft_q  <= snapLeft_d;
            snapRight_q <= snapRight_d;
            snapNeg_q   <= snapNeg_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_Tx   = tx_q;
    assign o_Busy = busy_q;
    assign o_Done = done_q;

endmodule

// File: tb/tb_result_uart_reporter.sv
// ---------------------------------------------------------------------------
// tb_result_uart_reporter
//
// Directed bench for result_uart_reporter with CLKS_PER_BIT=4. A bench-side
// UART receiver samples o_Tx mid-bit and compares every received character
// against a queue of expected characters filled when each request is issued.
// Honours REPORT_PARITY_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_result_uart_reporter;

   localparam int CPB = 4;
`ifdef REPORT_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int LINE_CYCLES = 8 * NBITS * CPB;

   logic clock = 1'b0;
   logic rstN;
   logic sendReq;
   logic [3:0] stateIn;
   logic [3:0] leftIn;
   logic [3:0] rightIn;
   logic negIn;
   logic txLine;
   logic busyOut;
   logic doneOut;

   int checks = 0;
   int errors = 0;
   logic [7:0] sbQ[$];
   int rxBytes = 0;
   int doneCount = 0;
   bit rxEnable = 1'b0;
   bit rxBusy = 1'b0;
   int rxCnt = 0;
   logic [7:0] rxByte;
   logic rxParity;

   result_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
      .i_Clk(clock),
      .i_Rst_L(rstN),
      .i_Send(sendReq),
      .i_State(stateIn),
      .i_Left(leftIn),
      .i_Right(rightIn),
      .i_Negative(negIn),
      .o_Tx(txLine),
      .o_Busy(busyOut),
      .o_Done(doneOut)
   );

   always #5 clock = ~clock;

   // One comparison: counts it, and on mismatch counts and reports the failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // ASCII hex digit from a lookup string, uppercase.
   function automatic logic [7:0] hexOf(input logic [3:0] n);
      string digits;
      digits = "0123456789ABCDEF";
      return digits[int'(n)];
   endfunction

   // Drives the status inputs, queues the expected line and pulses i_Send for
   // one cycle. Called at a negedge; returns at the following negedge.
   task automatic applyStimulus(input logic [3:0] s, input logic [3:0] l, input logic [3:0] r, input logic n);
      stateIn = s;
      leftIn  = l;
      rightIn = r;
      negIn   = n;
      sbQ.push_back(8'h53);
      sbQ.push_back(hexOf(s));
      sbQ.push_back(8'h20);
      sbQ.push_back(n ? 8'h2D : 8'h2B);
      sbQ.push_back(hexOf(l));
      sbQ.push_back(hexOf(r));
      sbQ.push_back(8'h0D);
      sbQ.push_back(8'h0A);
      sendReq = 1'b1;
      @(negedge clock);
      sendReq = 1'b0;
   endtask

   // Waits (bounded) for o_Done and checks the line took the full line time,
   // counting from the negedge right after acceptance.
   task automatic waitDone(input string tag, input int startCount);
      int n;
      n = startCount;
      while (doneOut !== 1'b1 && n < LINE_CYCLES + 200) begin
         @(negedge clock);
         n++;
      end
      checkOutput({tag, "_lineTime"}, n, LINE_CYCLES);
      checkOutput({tag, "_busyAtDone"}, {31'd0, busyOut}, 32'd0);
   endtask

   // Counts every cycle o_Done is seen high.
   always @(negedge clock) begin
      if (doneOut === 1'b1) doneCount++;
   end

   // Bench UART receiver: detects the start bit, samples each bit in the
   // middle of its CPB-cycle window and checks the byte against the queue.
   always @(negedge clock) begin
      int k;
      logic [7:0] expByte;
      if (!rxEnable || rstN !== 1'b1) begin
         rxBusy = 1'b0;
      end else if (!rxBusy) begin
         if (txLine === 1'b0) begin
            rxBusy = 1'b1;
            rxCnt  = 0;
         end
      end else begin
         rxCnt++;
         if (rxCnt % CPB == CPB / 2) begin
            k = rxCnt / CPB;
            if (k == 0) begin
               checkOutput("rxStartBit", {31'd0, txLine}, 32'd0);
            end else if (k <= 8) begin
               rxByte[k - 1] = txLine;
            end else if (k < NBITS - 1) begin
               rxParity = txLine;
            end else begin
               checkOutput("rxStopBit", {31'd0, txLine}, 32'd1);
               if (sbQ.size() == 0) begin
                  checkOutput("rxUnexpectedByte", {24'd0, rxByte}, 32'hFFFF_FFFF);
               end else begin
                  expByte = sbQ.pop_front();
                  checkOutput("rxByte", {24'd0, rxByte}, {24'd0, expByte});
`ifdef REPORT_PARITY_EN
                  checkOutput("rxParity", {31'd0, rxParity}, {31'd0, ^expByte});
`endif
               end
               rxBytes++;
               rxBusy = 1'b0;
            end
         end
      end
   end

   // Directed sequence.
   initial begin
      int base;
      int doneBase;
      rstN = 1'b0;
      sendReq = 1'b0;
      stateIn = 4'h0;
      leftIn = 4'h0;
      rightIn = 4'h0;
      negIn = 1'b0;

      // Reset held for three cycles.
      repeat (3) @(negedge clock);
      checkOutput("resetTx", {31'd0, txLine}, 32'd1);
      checkOutput("resetBusy", {31'd0, busyOut}, 32'd0);
      checkOutput("resetDone", {31'd0, doneOut}, 32'd0);
      rstN = 1'b1;
      rxEnable = 1'b1;
      @(negedge clock);

      // Basic line, negative result.
      base = rxBytes;
      applyStimulus(4'h3, 4'hA, 4'h5, 1'b1);
      checkOutput("t2_busyRise", {31'd0, busyOut}, 32'd1);
      checkOutput("t2_startBit", {31'd0, txLine}, 32'd0);
      waitDone("t2", 0);
      checkOutput("t2_byteCount", rxBytes - base, 8);
      checkOutput("t2_queueEmpty", sbQ.size(), 0);

      // Positive result; inputs changed mid-line must not leak into the bytes.
      @(negedge clock);
      checkOutput("t3_idleTx", {31'd0, txLine}, 32'd1);
      base = rxBytes;
      applyStimulus(4'hF, 4'h0, 4'h9, 1'b0);
      repeat (100) @(negedge clock);
      stateIn = 4'h1;
      leftIn = 4'h2;
      rightIn = 4'h3;
      negIn = 1'b1;
      waitDone("t3", 100);
      checkOutput("t3_byteCount", rxBytes - base, 8);

      // Request in the same cycle as o_Done: next line starts with no idle bit.
      // A second request during char 3 must be ignored.
      base = rxBytes;
      applyStimulus(4'h2, 4'hC, 4'h7, 1'b0);
      checkOutput("t4_busyBackToBack", {31'd0, busyOut}, 32'd1);
      checkOutput("t4_noIdleBit", {31'd0, txLine}, 32'd0);
      doneBase = doneCount;
      repeat (128) @(negedge clock);
      sendReq = 1'b1;
      @(negedge clock);
      sendReq = 1'b0;
      waitDone("t4", 129);
      repeat (100) @(negedge clock);
      checkOutput("t4_busyAfter", {31'd0, busyOut}, 32'd0);
      checkOutput("t4_singleDone", doneCount - doneBase, 1);
      checkOutput("t4_byteCount", rxBytes - base, 8);
      checkOutput("t4_queueEmpty", sbQ.size(), 0);

      // Reset during the data bits of char 2 aborts the line without o_Done.
      applyStimulus(4'h7, 4'hC, 4'h1, 1'b0);
      repeat (94) @(negedge clock);
      rxEnable = 1'b0;
      rstN = 1'b0;
      @(negedge clock);
      checkOutput("t5_abortTx", {31'd0, txLine}, 32'd1);
      checkOutput("t5_abortBusy", {31'd0, busyOut}, 32'd0);
      checkOutput("t5_abortDone", {31'd0, doneOut}, 32'd0);
      sbQ.delete();
      doneBase = doneCount;
      rstN = 1'b1;
      repeat (60) @(negedge clock);
      checkOutput("t5_noDone", doneCount - doneBase, 0);
      checkOutput("t5_idleBusy", {31'd0, busyOut}, 32'd0);
      checkOutput("t5_idleTx", {31'd0, txLine}, 32'd1);
      rxEnable = 1'b1;
      @(negedge clock);
      base = rxBytes;
      applyStimulus(4'h9, 4'h4, 4'hE, 1'b1);
      checkOutput("t5_busyRise", {31'd0, busyOut}, 32'd1);
      waitDone("t5", 0);
      checkOutput("t5_byteCount", rxBytes - base, 8);
      checkOutput("t5_queueEmpty", sbQ.size(), 0);

      repeat (5) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
